// File: rtl/load_store_unit.sv
// load_store_unit: one request at a time to a sync-read SPRAM; load 3 cycles, store/fault 2 cycles to response.
// Response held stable until rsp_ready, req_ready low meanwhile; `define LSU_STATS_EN to build the stat counters.
module load_store_unit #(
  parameter logic [31:0] MEM_BYTES = 32'h0020_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [11:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_exc,
  output logic [3:0]  rsp_cause,
  output logic [31:0] rsp_addr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_wr,
  output logic        mem_en,
  output logic [2:0]  mem_size,
  input  logic        mem_exception,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_faults
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] ea_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        exc_q;
  logic [3:0]  cause_q;

  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic        local_fault;
  logic [3:0]  cause_d;
  logic [31:0] ea_d;

  assign ea_d = req_base + {{20{req_offset[11]}}, req_offset};

  // Checks work only on registered request fields, so mem_wr has no path from mem_exception.
  always_comb begin
    illegal      = we_q ? (funct3_q[2] | (funct3_q[1:0] == 2'b11))
                        : ((funct3_q == 3'b011) | (funct3_q[2:1] == 2'b11));
    misaligned   = ((funct3_q[1:0] == 2'b01) & ea_q[0])
                 | ((funct3_q[1:0] == 2'b10) & (ea_q[1:0] != 2'b00));
    out_of_range = (ea_q >= MEM_BYTES);
    local_fault  = illegal | misaligned | out_of_range;
    cause_d      = 4'd0;
    if (illegal)            cause_d = 4'd2;
    else if (misaligned)    cause_d = we_q ? 4'd6 : 4'd4;
    else if (out_of_range)  cause_d = we_q ? 4'd7 : 4'd5;
    else if (mem_exception) cause_d = we_q ? 4'd6 : 4'd4;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        mem_en = 1'b1;
        mem_wr = we_q & ~local_fault;
        if (local_fault | mem_exception | we_q) state_d = S_RESP;
        else                                    state_d = S_WAIT;
      end
      S_WAIT: state_d = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ea_q     <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      exc_q    <= 1'b0;
      cause_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            ea_q     <= ea_d;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            wdata_q  <= req_wdata;
          end
        end
        S_ISSUE: begin
          exc_q   <= local_fault | mem_exception;
          cause_q <= cause_d;
          rdata_q <= '0;
        end
        S_WAIT: rdata_q <= mem_data_out;
        default: ;
      endcase
    end
  end

  // Request registers double as the memory port holding registers between accesses.
  assign mem_addr    = ea_q;
  assign mem_size    = funct3_q;
  assign mem_data_in = wdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_exc     = exc_q;
  assign rsp_cause   = cause_q;
  assign rsp_addr    = ea_q;

`ifdef LSU_STATS_EN
  logic        rsp_fire;
  logic [31:0] loads_q, stores_q, faults_q;

  assign rsp_fire = rsp_valid & rsp_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      loads_q  <= '0;
      stores_q <= '0;
      faults_q <= '0;
    end else if (rsp_fire) begin
      if (exc_q)      faults_q <= faults_q + 32'd1;
      else if (we_q)  stores_q <= stores_q + 32'd1;
      else            loads_q  <= loads_q + 32'd1;
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_faults = faults_q;
`else
  assign stat_loads  = '0;
  assign stat_stores = '0;
  assign stat_faults = '0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-lane formatting SPRAM model attached to the memory ports.
module tb_load_store_unit;
  logic        CLK;
  logic        RST_N;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [11:0] req_offset;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_exc;
  logic [3:0]  rsp_cause;
  logic [31:0] rsp_addr;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_wr;
  logic        mem_en;
  logic [2:0]  mem_size;
  logic        mem_exception;
  logic [31:0] stat_loads, stat_stores, stat_faults;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int wr_before;
  logic inj = 1'b0;

`ifdef LSU_STATS_EN
  localparam logic [31:0] EXP_LOADS = 32'd3, EXP_STORES = 32'd2, EXP_FAULTS = 32'd1;
`else
  localparam logic [31:0] EXP_LOADS = 32'd0, EXP_STORES = 32'd0, EXP_FAULTS = 32'd0;
`endif

  load_store_unit dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_funct3(req_funct3),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_exc(rsp_exc),
    .rsp_cause(rsp_cause), .rsp_addr(rsp_addr),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_wr(mem_wr), .mem_en(mem_en), .mem_size(mem_size), .mem_exception(mem_exception),
    .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_faults(stat_faults)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign mem_exception = inj & mem_en;

  logic [31:0] mem [0:1023];

  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] a, input logic [2:0] sz);
    logic [31:0] s;
    s = w >> {a, 3'b000};
    case (sz)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] a,
                                        input logic [2:0] sz, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (sz[1:0])
      2'b00:   r[{a, 3'b000} +: 8] = d[7:0];
      2'b01:   r[{a[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge CLK) begin
    if (mem_en && mem_wr) begin
      mem[mem_addr[11:2]] <= merge(mem[mem_addr[11:2]], mem_addr[1:0], mem_size, mem_data_in);
      wr_cnt <= wr_cnt + 1;
    end else if (mem_en) begin
      mem_data_out <= fmt(mem[mem_addr[11:2]], mem_addr[1:0], mem_size);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request and checks the response fields once rsp_valid rises.
  task automatic txn(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] base,
                     input logic [11:0] off, input logic [31:0] wd, input int exp_lat,
                     input logic exp_exc, input logic [3:0] exp_cause, input logic [31:0] exp_addr,
                     input logic [31:0] exp_rdata, input logic ack);
    int edges;
    @(negedge CLK);
    check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wd;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    edges = 1;
    while (!rsp_valid && edges < 20) begin
      @(posedge CLK);
      #1 edges++;
    end
    check({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, ".latency"}, edges, exp_lat);
    check({tag, ".rsp_exc"}, {31'd0, rsp_exc}, {31'd0, exp_exc});
    check({tag, ".rsp_cause"}, {28'd0, rsp_cause}, {28'd0, exp_cause});
    check({tag, ".rsp_addr"}, rsp_addr, exp_addr);
    check({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
    if (ack) ack_rsp(tag);
  endtask

  task automatic ack_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge CLK);
    #1 rsp_ready = 1'b0;
    check({tag, ".drop_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, ".idle_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    RST_N = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_base = '0; req_offset = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst.req_ready", {31'd0, req_ready}, 32'd1);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.mem_en", {31'd0, mem_en}, 32'd0);
    check("rst.mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.stat_loads", stat_loads, 32'd0);
    @(negedge CLK) RST_N = 1'b1;

    wr_before = wr_cnt;
    txn("sw104", 1'b1, 3'b010, 32'h100, 12'h004, 32'hDEADBEEF, 2, 1'b0, 4'd0, 32'h104, 32'h0, 1'b1);
    check("sw104.wr_count", wr_cnt, wr_before + 1);
    txn("lw104", 1'b0, 3'b010, 32'h104, 12'h000, 32'h0, 3, 1'b0, 4'd0, 32'h104, 32'hDEADBEEF, 1'b1);
    txn("sw100", 1'b1, 3'b010, 32'h100, 12'h000, 32'h11223344, 2, 1'b0, 4'd0, 32'h100, 32'h0, 1'b1);
    txn("sw200", 1'b1, 3'b010, 32'h200, 12'h000, 32'h80FF7F01, 2, 1'b0, 4'd0, 32'h200, 32'h0, 1'b1);
    txn("lb203", 1'b0, 3'b000, 32'h200, 12'h003, 32'h0, 3, 1'b0, 4'd0, 32'h203, 32'hFFFFFF80, 1'b1);
    txn("lbu203", 1'b0, 3'b100, 32'h200, 12'h003, 32'h0, 3, 1'b0, 4'd0, 32'h203, 32'h00000080, 1'b1);
    txn("lh202", 1'b0, 3'b001, 32'h200, 12'h002, 32'h0, 3, 1'b0, 4'd0, 32'h202, 32'hFFFF80FF, 1'b1);
    txn("lhu200", 1'b0, 3'b101, 32'h200, 12'h000, 32'h0, 3, 1'b0, 4'd0, 32'h200, 32'h00007F01, 1'b1);

    wr_before = wr_cnt;
    txn("sw102", 1'b1, 3'b010, 32'h100, 12'h002, 32'h55555555, 2, 1'b1, 4'd6, 32'h102, 32'h0, 1'b1);
    check("sw102.no_write", wr_cnt, wr_before);
    txn("lw100", 1'b0, 3'b010, 32'h100, 12'h000, 32'h0, 3, 1'b0, 4'd0, 32'h100, 32'h11223344, 1'b1);

    txn("lw_oor", 1'b0, 3'b010, 32'h0020_0000, 12'h000, 32'h0, 2, 1'b1, 4'd5, 32'h0020_0000, 32'h0, 1'b1);
    txn("sw_oor", 1'b1, 3'b010, 32'h001F_FFFC, 12'h004, 32'h1, 2, 1'b1, 4'd7, 32'h0020_0000, 32'h0, 1'b1);
    txn("st_f100", 1'b1, 3'b100, 32'h100, 12'h000, 32'h1, 2, 1'b1, 4'd2, 32'h100, 32'h0, 1'b1);
    txn("ld_f011", 1'b0, 3'b011, 32'h100, 12'h000, 32'h0, 2, 1'b1, 4'd2, 32'h100, 32'h0, 1'b1);
    txn("lh201", 1'b0, 3'b001, 32'h200, 12'h001, 32'h0, 2, 1'b1, 4'd4, 32'h201, 32'h0, 1'b1);
    txn("sw_neg", 1'b1, 3'b010, 32'h10, 12'hFF0, 32'hCAFEF00D, 2, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
    txn("lw0", 1'b0, 3'b010, 32'h0, 12'h000, 32'h0, 3, 1'b0, 4'd0, 32'h0, 32'hCAFEF00D, 1'b1);

    inj = 1'b1;
    txn("lw_memexc", 1'b0, 3'b010, 32'h104, 12'h000, 32'h0, 2, 1'b1, 4'd4, 32'h104, 32'h0, 1'b1);
    inj = 1'b0;

    txn("bp", 1'b0, 3'b010, 32'h104, 12'h000, 32'h0, 3, 1'b0, 4'd0, 32'h104, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      check("bp.rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp.rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp.req_ready", {31'd0, req_ready}, 32'd0);
    end
    ack_rsp("bp");

    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_base = 32'h104; req_offset = '0;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(posedge CLK);
    #1;
    check("rstw.in_wait_en", {31'd0, mem_en}, 32'd0);
    RST_N = 1'b0;
    #1;
    check("rstw.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstw.req_ready", {31'd0, req_ready}, 32'd1);
    check("rstw.mem_addr", mem_addr, 32'd0);
    check("rstw.stat_faults", stat_faults, 32'd0);
    @(negedge CLK) RST_N = 1'b1;

    txn("st_l1", 1'b0, 3'b010, 32'h104, 12'h000, 32'h0, 3, 1'b0, 4'd0, 32'h104, 32'hDEADBEEF, 1'b1);
    txn("st_l2", 1'b0, 3'b010, 32'h100, 12'h000, 32'h0, 3, 1'b0, 4'd0, 32'h100, 32'h11223344, 1'b1);
    txn("st_l3", 1'b0, 3'b100, 32'h200, 12'h003, 32'h0, 3, 1'b0, 4'd0, 32'h203, 32'h00000080, 1'b1);
    txn("st_s1", 1'b1, 3'b010, 32'h108, 12'h000, 32'h12345678, 2, 1'b0, 4'd0, 32'h108, 32'h0, 1'b1);
    txn("st_s2", 1'b1, 3'b000, 32'h10C, 12'h000, 32'hAB, 2, 1'b0, 4'd0, 32'h10C, 32'h0, 1'b1);
    txn("st_f1", 1'b0, 3'b010, 32'h101, 12'h000, 32'h0, 2, 1'b1, 4'd4, 32'h101, 32'h0, 1'b1);
    txn("st_chk", 1'b0, 3'b010, 32'h108, 12'h000, 32'h0, 3, 1'b0, 4'd0, 32'h108, 32'h12345678, 1'b0);
    check("stat_loads", stat_loads, EXP_LOADS);
    check("stat_stores", stat_stores, EXP_STORES);
    check("stat_faults", stat_faults, EXP_FAULTS);
    ack_rsp("st_chk");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Load/store unit between the CPU execute stage and the data memory block (single-cycle synchronous-read SPRAM wrapper with funct3-style size encoding and byte-lane formatting).
- Accepts one request at a time over a valid/ready handshake and computes the effective address.
- Checks funct3 legality, alignment and range, then drives the memory ports with stable address and size across the read-latency cycle.
- Returns load data, store completion, or a RISC-V exception cause over a valid/ready response channel.

Parameters:
MEM_BYTES, 32'h0020_0000, size of the data memory in bytes; effective addresses >= MEM_BYTES raise an access fault.

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  unit can accept a request
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_base  input  32  rs1 value
req_offset  input  12  signed immediate
req_wdata  input  32  store data, unshifted, in low bits
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  32  formatted load data; 0 for stores and exceptions
rsp_exc  output  1  request faulted
rsp_cause  output  4  mcause code when rsp_exc=1, else 0
rsp_addr  output  32  effective address (mtval on fault)
mem_addr  output  32  to memory addr
mem_data_in  output  32  to memory data_in
mem_data_out  input  32  from memory data_out
mem_wr  output  1  to memory wr
mem_en  output  1  to memory en
mem_size  output  3  to memory size
mem_exception  input  1  from memory exception
stat_loads, stat_stores, stat_faults  output  32 each  statistics counters (see Optional Feature)

Behaviour:
- Reset (async, RST_N=0): state IDLE. All request registers clear. All outputs 0 except req_ready=1.
- Effective address: ea = req_base + sign_extend(req_offset); 32-bit wrap-around, no fault on overflow.
- State IDLE:
  - req_ready=1.
  - On req_valid: latch ea, funct3, we and wdata into registers; go to ISSUE.
- Fault check, in priority order, evaluated in ISSUE from registered values:
  - Illegal funct3 gives cause 2: loads with 011/110/111; stores with any funct3 other than 000/001/010.
  - Misaligned gives cause 4 for loads, 6 for stores: half with ea[0]=1, or word with ea[1:0]!=0.
  - Out of range (ea >= MEM_BYTES) gives cause 5 for loads, 7 for stores.
  - A mem_exception=1 during ISSUE with no local fault is reported as misaligned (4/6).
- State ISSUE (1 cycle):
  - mem_addr=ea, mem_size=funct3, mem_data_in=wdata, mem_en=1.
  - mem_wr = we and no fault; a faulted store never writes memory.
  - Faulted request: go to RESP with rsp_exc=1 and the cause.
  - Good store: write commits at the ISSUE clock edge; go to RESP.
  - Good load: go to WAIT.
- State WAIT (1 cycle, loads only):
  - mem_addr and mem_size held at the ISSUE values; mem_en=0, mem_wr=0.
  - Capture mem_data_out into rsp_rdata at the clock edge; go to RESP.
- State RESP:
  - rsp_valid=1; rsp_rdata, rsp_exc, rsp_cause and rsp_addr stay stable until rsp_ready=1.
  - On rsp_ready, go to IDLE; rsp_valid drops the next cycle.
  - req_ready=0 in ISSUE, WAIT and RESP, so there is no back-to-back acceptance.
- Latency, counted from the accept edge to rsp_valid high:
  - Load: 3 cycles.
  - Store or any fault: 2 cycles.
  - Throughput: at most one request per 4 cycles (load) or 3 cycles (store) with rsp_ready held at 1.
- Memory ports outside ISSUE/WAIT: mem_en=0, mem_wr=0; mem_addr and mem_size hold their last value.
- Reset mid-operation: abandons the request immediately. A store whose ISSUE edge did not complete does not write.

Optional Feature:
Macro LSU_STATS_EN.
- Defined:
  - stat_loads increments on each load response handshake with rsp_exc=0.
  - stat_stores increments on each store response handshake with rsp_exc=0.
  - stat_faults increments on each response handshake with rsp_exc=1.
  - All three are 32-bit, wrap at 2^32, and reset to 0.
- Not defined: the counters are not built and all three stat ports are tied to 0.

Test Plan:
- Word store then load: store base=0x100, offset=0x004, wdata=0xDEADBEEF. Then load w from base=0x104, offset=0 -> rsp_rdata=0xDEADBEEF, rsp_exc=0, rsp_valid 3 cycles after accept.
- Byte load sign extension: memory word at 0x200 = 0x80FF7F01. lb 0x203 -> 0xFFFFFF80; lbu 0x203 -> 0x00000080; lh 0x202 -> 0xFFFF80FF; lhu 0x200 -> 0x00007F01.
- Misaligned store: sw at ea=0x102 -> rsp_exc=1, rsp_cause=6, rsp_addr=0x102, mem_wr never asserted; a later lw 0x100 returns the old value.
- Range and illegal: lw at 0x00200000 -> cause 5. Store with funct3=100 -> cause 2. Negative offset: base=0x10, offset=0xFF0 -> ea=0x0, legal.
- Backpressure and reset: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0. Assert RST_N=0 during WAIT -> rsp_valid=0 and req_ready=1 immediately.
- With LSU_STATS_EN: 3 good loads, 2 good stores, 1 fault -> stat_loads=3, stat_stores=2, stat_faults=1. Without the macro all three read 0.
